// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-pair scan controller: shifts one BCM bit plane per pass from a
// framebuffer port, latches it, then shows it for a significance-weighted time.
module hub75_scan_ctrl #(
   parameter int  COLS      = 32,
   parameter int  ROW_PAIRS = 16,
   parameter int  BPP       = 4,
   parameter int  CLK_DIV   = 4,
   parameter int  BASE_ON   = 8,
   localparam int ADDR_W    = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1,
   localparam int COL_W     = $clog2(COLS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   output logic [ADDR_W+COL_W-1:0] rd_addr,
   input  logic [6*BPP-1:0]        rd_data,
   output logic                    r0,
   output logic                    g0,
   output logic                    b0,
   output logic                    r1,
   output logic                    g1,
   output logic                    b1,
   output logic                    hub_clk,
   output logic                    hub_lat,
   output logic                    hub_oe_n,
   output logic [ADDR_W-1:0]       hub_addr,
   output logic                    frame_start
);

   localparam int PL_W   = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int MAX_ON = BASE_ON << (BPP - 1);
   localparam int ON_W   = $clog2(MAX_ON + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROW_PAIRS - 1);
   localparam logic [PL_W-1:0]   PL_LAST  = PL_W'(BPP - 1);

   typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, GAP} state_t;

   state_t                  state_q;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    tick;
   logic [ADDR_W-1:0]       row_q, row_next;
   logic [PL_W-1:0]         plane_q;
   logic [COL_W-1:0]        col_q, col_inc;
   logic [ON_W-1:0]         on_q, on_last;
   logic                    phase_q;
   logic                    plane_wrap, row_wrap;
   logic [5:0][BPP-1:0]     fld;

   logic                    r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
   logic                    hub_clk_q, hub_lat_q, hub_oe_n_q, frame_start_q;
   logic [ADDR_W-1:0]       hub_addr_q;
   logic [ADDR_W+COL_W-1:0] rd_addr_q;

   // Pixel word fields, lowest first: B0, G0, R0, B1, G1, R1.
   assign fld = rd_data;

   assign tick       = (div_q == DIV_LAST);
   assign col_inc    = col_q + 1'b1;
   assign plane_wrap = (plane_q == PL_LAST);
   assign row_wrap   = (row_q == ROW_LAST);
   assign on_last    = ON_W'((BASE_ON << plane_q) - 1);

   always_comb begin
      // NOTE: every combinational output gets a value before any condition,
      // so no path can leave it unassigned and infer a latch.
      div_d    = div_q + 1'b1;
      row_next = row_q;
      if (tick) div_d = '0;
      if (plane_wrap) row_next = row_wrap ? '0 : row_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // NOTE: state and outputs use non-blocking assignments only, so every
   // branch below sees the pre-edge values of row, plane and col.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         row_q         <= '0;
         plane_q       <= '0;
         col_q         <= '0;
         on_q          <= '0;
         phase_q       <= 1'b0;
         r0_q          <= 1'b0;
         g0_q          <= 1'b0;
         b0_q          <= 1'b0;
         r1_q          <= 1'b0;
         g1_q          <= 1'b0;
         b1_q          <= 1'b0;
         hub_clk_q     <= 1'b0;
         hub_lat_q     <= 1'b0;
         hub_oe_n_q    <= 1'b1;
         hub_addr_q    <= '0;
         rd_addr_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         if (tick) begin
            case (state_q)
               IDLE: begin
                  hub_oe_n_q <= 1'b1;
                  if (enable) begin
                     row_q         <= '0;
                     plane_q       <= '0;
                     col_q         <= '0;
                     phase_q       <= 1'b0;
                     rd_addr_q     <= '0;
                     frame_start_q <= 1'b1;
                     state_q       <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (!phase_q) begin
                     hub_clk_q <= 1'b0;
                     b0_q      <= fld[0][plane_q];
                     g0_q      <= fld[1][plane_q];
                     r0_q      <= fld[2][plane_q];
                     b1_q      <= fld[3][plane_q];
                     g1_q      <= fld[4][plane_q];
                     r1_q      <= fld[5][plane_q];
                     phase_q   <= 1'b1;
                  end else begin
                     hub_clk_q <= 1'b1;
                     phase_q   <= 1'b0;
                     col_q     <= col_inc;
                     rd_addr_q <= {row_q, col_inc};
                     if (col_q == COL_LAST) state_q <= LATCH;
                  end
               end
               LATCH: begin
                  // Row address moves with the latch pulse, while still blanked.
                  if (!phase_q) begin
                     hub_lat_q  <= 1'b1;
                     hub_addr_q <= row_q;
                     phase_q    <= 1'b1;
                  end else begin
                     hub_lat_q <= 1'b0;
                     phase_q   <= 1'b0;
                     on_q      <= '0;
                     state_q   <= SHOW;
                  end
               end
               SHOW: begin
                  hub_oe_n_q <= 1'b0;
                  if (on_q == on_last) state_q <= GAP;
                  else                 on_q    <= on_q + 1'b1;
               end
               GAP: begin
                  hub_oe_n_q <= 1'b1;
                  plane_q    <= plane_wrap ? '0 : plane_q + 1'b1;
                  row_q      <= row_next;
                  col_q      <= '0;
                  phase_q    <= 1'b0;
                  rd_addr_q  <= {row_next, {COL_W{1'b0}}};
                  if (enable) begin
                     frame_start_q <= plane_wrap && row_wrap;
                     state_q       <= SHIFT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign r0          = r0_q;
   assign g0          = g0_q;
   assign b0          = b0_q;
   assign r1          = r1_q;
   assign g1          = g1_q;
   assign b1          = b1_q;
   assign hub_clk     = hub_clk_q;
   assign hub_lat     = hub_lat_q;
   assign hub_oe_n    = hub_oe_n_q;
   assign hub_addr    = hub_addr_q;
   assign rd_addr     = rd_addr_q;
   assign frame_start = frame_start_q;

endmodule
